// File: rtl/seq_mult_acc.sv
// Sequential shift-add multiplier-accumulator: one multiplier bit per clock,
// W-bit operands, 2W-bit result register with optional accumulate and signed modes.
module seq_mult_acc #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    input  logic           acc,
    output logic [2*W-1:0] p,
    output logic           ready,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    mcand_q;
    logic [W-1:0]    mplier_q;
    logic [2*W-1:0]  pp_q;
    logic [2*W-1:0]  p_q;
    logic [CntW-1:0] cnt_q;
    logic            neg_q;
    logic            acc_q;

    logic [W:0]      add_term;
    logic [W:0]      upper_sum;
    logic [2*W:0]    pp_wide;
    logic [2*W-1:0]  pp_step;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            last_iter;
    logic            accept;

    always_comb begin
        add_term  = mplier_q[0] ? {1'b0, mcand_q} : '0;
        // Carry out of the upper half is kept and lands in the MSB after the shift.
        upper_sum = {1'b0, pp_q[2*W-1:W]} + add_term;
        pp_wide   = {upper_sum, pp_q[W-1:0]};
        pp_step   = pp_wide[2*W:1];
        prod      = neg_q ? -pp_step : pp_step;
        last_iter = (cnt_q == CntW'(W - 1));
        // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
        a_mag     = (signed_mode && a[W-1]) ? -a : a;
        b_mag     = (signed_mode && b[W-1]) ? -b : b;
        accept    = start && (state_q != StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            pp_q     <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        pp_q     <= '0;
                        cnt_q    <= '0;
                        neg_q    <= signed_mode & (a[W-1] ^ b[W-1]);
                        acc_q    <= acc;
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StRun: begin
                    pp_q     <= pp_step;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_iter) begin
                        p_q     <= acc_q ? (p_q + prod) : prod;
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign p     = p_q;
    assign ready = (state_q != StRun);
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);

endmodule

// File: doc/seq_mult_acc.md
# seq_mult_acc

Parametrised sequential shift-add multiplier-accumulator, the W-bit generalisation of the team's 4x4 multiplier benchmark block. It takes two W-bit operands on a START/READY handshake, retires one multiplier bit per clock, and writes a 2W-bit product into the result register. An optional accumulate mode adds the product to the previous result. Optional signed mode treats both operands as two's complement. It sits in the benchmark datapath wherever a small, area-cheap multiply is preferred over speed.

## Interface
- W, default 4: operand width, integer >= 2; result width is 2W.
- CK  in  1  clock; all state changes on rising edge.
- RSTN  in  1  reset, asynchronous and active-low.
- START  in  1  request; accepted only on an edge where READY=1.
- A  in  W  multiplicand, sampled on the accept edge.
- B  in  W  multiplier, sampled on the accept edge.
- SIGNED  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the accept edge.
- ACC  in  1  1 = P <= P + product, 0 = P <= product; sampled on the accept edge.
- P  out  2W  result register; changes only on a completion edge or at reset.
- READY  out  1  block can accept START (states IDLE, DONE).
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse; P is valid and newly written.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE with P=0, READY=1, BUSY=0, DONE=0, iteration counter=0.
- IDLE, START=1 -> RUN. Register |A| and |B| as W-bit magnitudes, plus the flags neg = SIGNED & (A[W-1] ^ B[W-1]), ACC and counter=0. Clear the 2W-bit partial product.
- Magnitude in signed mode: a negative operand is negated modulo 2^W. -2^(W-1) maps to unsigned 2^(W-1), which is correct.
- RUN, each cycle: if the current multiplier bit = 1, add the multiplicand to the upper W bits of the partial product with carry-out kept (W+1 bits). Shift the partial product right by 1, shift the multiplier right by 1, and increment the counter.
- RUN, on the W-th iteration edge: form prod = neg ? -pp : pp (mod 2^2W). P <= ACC ? P + prod : prod, with 2W-bit wrap and no saturation. State -> DONE.
- DONE: DONE=1, READY=1. With START=1 the request is accepted exactly as from IDLE (-> RUN, back-to-back). Otherwise -> IDLE.
- START in RUN is ignored. It is not queued and has no effect on the operands or flags in flight.
- A, B, SIGNED and ACC may change freely after the accept edge.
- RSTN low at any time: immediately abort, return to IDLE, P=0. The in-flight operation is lost and no DONE is issued.
- Signed range: the product always fits in 2W signed bits, with maximum (-2^(W-1))^2 = 2^(2W-2).

## Timing
- Accept edge = edge 0. BUSY is high for the W cycles after edge 0.
- P is written and DONE rises on edge W. The DONE pulse lasts exactly one cycle, unless a new operation completes in it, which is impossible for W >= 2.
- Throughput: one product per W+1 cycles when START is held high.
- READY is combinational from state, and is low exactly while BUSY is high.
- P does not glitch or expose partial values during RUN.

## Test plan
- Reset: RSTN low with random inputs -> P=0, READY=1, BUSY=0, DONE=0. Release, then hold START=0 for 10 cycles -> outputs unchanged.
- Unsigned, W=4: A=13, B=11, SIGNED=0, ACC=0 -> BUSY for 4 cycles, DONE on edge 4, P=0x8F (143). Then exhaustively sweep all 256 operand pairs against a reference model.
- Signed, W=4: A=-3 (0xD), B=5 -> P=0xF1 (-15). A=-8, B=-8 -> P=0x40. A=-8, B=7 -> P=0xC8 (-56). A=0, B=-1 -> P=0x00.
- Accumulate, W=4 unsigned: 15*15 with ACC=0 -> P=0xE1. Then 15*15 with ACC=1 -> P=0xC2 (450 mod 256). Then signed -1*1 with ACC=1 -> P=0xC1.
- Handshake: hold START=1 continuously -> accept edges every 5 cycles and DONE every 5 cycles. Toggle A and B and pulse START mid-RUN -> result unaffected, no extra operation.
- Reset mid-op: assert RSTN on RUN cycle 2 -> P=0 immediately, no DONE. The next START -> correct result. Repeat the unsigned and signed checks with W=8 (e.g. 255*255=0xFE01, signed -128*-128=0x4000).
